// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg
//   Shared types for the FP issue scheduler.
//   - FP_AW         : FP register address width
//   - long_state_e  : state of the single iterative (fdiv/fsqrt) unit tracker
//   - short_entry_t : one stage of the fixed-latency short-op pipe
package fpu_sched_pkg;

    localparam int FP_AW = 5;

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_BUSY = 2'd1,
        L_HOLD = 2'd2
    } long_state_e;

    typedef struct packed {
        logic             valid;
        logic             fd_en;
        logic [FP_AW-1:0] fd;
    } short_entry_t;

endpackage

// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard
//   One busy bit per FP register. A register becomes busy when an op that
//   writes it issues and becomes free on the cycle its writeback happens.
//   The hazard check looks only at the registered busy bits, so a bit that is
//   being cleared this cycle still reads as busy (no bypass).
// Ports
//   clk, rst            : clock, synchronous active-high reset (all bits free)
//   set_en, set_addr    : mark set_addr busy at the next edge
//   clr_en, clr_addr    : mark clr_addr free at the next edge
//   fs_en[2:0]          : source enables {fs3, fs2, fs1}
//   fs1/fs2/fs3_addr    : source registers to check (RAW)
//   fd_en, fd_addr      : destination to check (WAW)
//   hazard              : any enabled source or destination is busy
module fpu_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [2:0]    fs_en,
    input  logic [AW-1:0] fs1_addr,
    input  logic [AW-1:0] fs2_addr,
    input  logic [AW-1:0] fs3_addr,
    input  logic          fd_en,
    input  logic [AW-1:0] fd_addr,
    output logic          hazard
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Set and clear never target the same register in one cycle: a register
    // being written back is busy, so the WAW check keeps it from being set.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hazard = (fs_en[0] & busy_q[fs1_addr])
                  | (fs_en[1] & busy_q[fs2_addr])
                  | (fs_en[2] & busy_q[fs3_addr])
                  | (fd_en    & busy_q[fd_addr]);

endmodule

// File: rtl/fpu_issue_sched.sv
// fpu_issue_sched
//   Issue scheduler between FP decode and FP execution. A decoded op is held
//   until its registers are hazard-free, then started. Short ops enter a
//   LAT_SHORT-deep pipe; long ops (fdiv/fsqrt) go to one iterative unit that
//   pulses long_done. Both result streams share the single register-file
//   write port, short results taking priority.
// Parameters
//   NREG      : number of FP registers
//   LAT_SHORT : cycles from ex_start to short-op writeback (>= 1)
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   dec_valid / dec_ready     : decode handshake (see below)
//   dec_fs_en, dec_fs*_addr   : source read enables {fs3,fs2,fs1} and addresses
//   dec_fd_en, dec_fd_addr    : destination write enable and address
//   dec_long                  : op is fdiv/fsqrt
//   ex_start, ex_long         : start pulse to execution, started op is long
//   long_done                 : long unit result ready (1-cycle pulse)
//   wb_valid, wb_addr, wb_sel : register-file write (wb_sel 1 = long result)
//   halt_req                  : long unit not idle
//   perf_raw_stall, perf_long_cnt : only with FPU_SCHED_PERF_EN defined;
//                               stalled-cycle and long-issue counters,
//                               saturating at 16'hFFFF
// Handshake: an op transfers in a cycle where dec_valid and dec_ready are both
//   high; dec_ready is never high without dec_valid and is combinational on the
//   dec_* inputs. ex_start is that transfer. dec_* must stay stable while
//   dec_valid is high and dec_ready is low.
module fpu_issue_sched
    import fpu_sched_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int LAT_SHORT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [2:0]       dec_fs_en,
    input  logic [FP_AW-1:0] dec_fs1_addr,
    input  logic [FP_AW-1:0] dec_fs2_addr,
    input  logic [FP_AW-1:0] dec_fs3_addr,
    input  logic             dec_fd_en,
    input  logic [FP_AW-1:0] dec_fd_addr,
    input  logic             dec_long,
    output logic             ex_start,
    output logic             ex_long,
    input  logic             long_done,
    output logic             wb_valid,
    output logic [FP_AW-1:0] wb_addr,
    output logic             wb_sel,
    output logic             halt_req
`ifdef FPU_SCHED_PERF_EN
    ,
    output logic [15:0]      perf_raw_stall,
    output logic [15:0]      perf_long_cnt
`endif
);

    localparam int AW = $clog2(NREG);

    long_state_e      state_q, state_d;
    logic             lfd_en_q, lfd_en_d;
    logic [FP_AW-1:0] lfd_q, lfd_d;

    short_entry_t     sp_q [LAT_SHORT];
    short_entry_t     sp_in_d;
    short_entry_t     tail;

    logic hazard;
    logic port_ok;
    logic issue;
    logic short_issue;
    logic tail_wr;
    logic long_wr;

    // ------------------------------------------------------------------
    // Issue decision
    // ------------------------------------------------------------------
    fpu_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue & dec_fd_en),
        .set_addr (dec_fd_addr[AW-1:0]),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr[AW-1:0]),
        .fs_en    (dec_fs_en),
        .fs1_addr (dec_fs1_addr[AW-1:0]),
        .fs2_addr (dec_fs2_addr[AW-1:0]),
        .fs3_addr (dec_fs3_addr[AW-1:0]),
        .fd_en    (dec_fd_en),
        .fd_addr  (dec_fd_addr[AW-1:0]),
        .hazard   (hazard)
    );

    // Long ops need the unit free; short ops are held off only while a long
    // result waits for the write port, so the short pipe can drain.
    always_comb begin
        port_ok = 1'b0;
        if (dec_long) begin
            port_ok = (state_q == L_IDLE);
        end else begin
            port_ok = (state_q != L_HOLD);
        end
    end

    assign dec_ready   = dec_valid & ~hazard & port_ok;
    assign issue       = dec_ready;
    assign short_issue = issue & ~dec_long;
    assign ex_start    = issue;
    assign ex_long     = issue & dec_long;

    // ------------------------------------------------------------------
    // Short pipe: stage 0 is loaded on issue, the last stage is the tail
    // whose result goes to the write port in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        sp_in_d = '0;
        if (short_issue) begin
            sp_in_d.valid = 1'b1;
            sp_in_d.fd_en = dec_fd_en;
            sp_in_d.fd    = dec_fd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT_SHORT; i++) begin
                sp_q[i] <= '0;
            end
        end else begin
            sp_q[0] <= sp_in_d;
            for (int i = 1; i < LAT_SHORT; i++) begin
                sp_q[i] <= sp_q[i-1];
            end
        end
    end

    assign tail    = sp_q[LAT_SHORT-1];
    assign tail_wr = tail.valid & tail.fd_en;

    // ------------------------------------------------------------------
    // Long unit tracker
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= L_IDLE;
            lfd_en_q <= 1'b0;
            lfd_q    <= '0;
        end else begin
            state_q  <= state_d;
            lfd_en_q <= lfd_en_d;
            lfd_q    <= lfd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lfd_en_d = lfd_en_q;
        lfd_d    = lfd_q;
        long_wr  = 1'b0;
        case (state_q)
            L_IDLE: begin
                // long_done is ignored here, e.g. after a reset mid-operation
                if (ex_long) begin
                    state_d  = L_BUSY;
                    lfd_en_d = dec_fd_en;
                    lfd_d    = dec_fd_addr;
                end
            end
            L_BUSY: begin
                if (long_done) begin
                    if (!lfd_en_q) begin
                        state_d = L_IDLE;
                    end else if (tail_wr) begin
                        state_d = L_HOLD;
                    end else begin
                        long_wr = 1'b1;
                        state_d = L_IDLE;
                    end
                end
            end
            L_HOLD: begin
                // No new short ops enter while here, so the tail empties
                // within LAT_SHORT cycles.
                if (!tail_wr) begin
                    long_wr = 1'b1;
                    state_d = L_IDLE;
                end
            end
            default: begin
                state_d = L_IDLE;
            end
        endcase
    end

    assign halt_req = (state_q != L_IDLE);

    // ------------------------------------------------------------------
    // Write port: long_wr is only raised when the tail is not writing.
    // ------------------------------------------------------------------
    assign wb_valid = tail_wr | long_wr;
    assign wb_sel   = long_wr;
    assign wb_addr  = tail_wr ? tail.fd : (long_wr ? lfd_q : '0);

`ifdef FPU_SCHED_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] long_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            long_cnt_q  <= '0;
        end else begin
            if (dec_valid && !dec_ready && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (ex_long && long_cnt_q != 16'hFFFF) begin
                long_cnt_q <= long_cnt_q + 16'd1;
            end
        end
    end

    assign perf_raw_stall = stall_cnt_q;
    assign perf_long_cnt  = long_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_issue_sched.sv
// tb_fpu_issue_sched
//   Directed bench for fpu_issue_sched. Expected register-file writes
//   ({wb_sel, wb_addr}) are queued when the op is issued; a monitor thread
//   pops and compares on every wb_valid. Issue timing and stall behaviour are
//   checked inline. Perf counters are checked when FPU_SCHED_PERF_EN is set.
module tb_fpu_issue_sched;

  localparam int LAT = 3;

  logic       clk;
  logic       rst;
  logic       dec_valid;
  logic       dec_ready;
  logic [2:0] dec_fs_en;
  logic [4:0] dec_fs1_addr;
  logic [4:0] dec_fs2_addr;
  logic [4:0] dec_fs3_addr;
  logic       dec_fd_en;
  logic [4:0] dec_fd_addr;
  logic       dec_long;
  logic       ex_start;
  logic       ex_long;
  logic       long_done;
  logic       wb_valid;
  logic [4:0] wb_addr;
  logic       wb_sel;
  logic       halt_req;
`ifdef FPU_SCHED_PERF_EN
  logic [15:0] perf_raw_stall;
  logic [15:0] perf_long_cnt;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [5:0] exp_q[$];

  fpu_issue_sched #(
    .NREG      (32),
    .LAT_SHORT (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_fs_en    (dec_fs_en),
    .dec_fs1_addr (dec_fs1_addr),
    .dec_fs2_addr (dec_fs2_addr),
    .dec_fs3_addr (dec_fs3_addr),
    .dec_fd_en    (dec_fd_en),
    .dec_fd_addr  (dec_fd_addr),
    .dec_long     (dec_long),
    .ex_start     (ex_start),
    .ex_long      (ex_long),
    .long_done    (long_done),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_sel       (wb_sel),
    .halt_req     (halt_req)
`ifdef FPU_SCHED_PERF_EN
    ,
    .perf_raw_stall (perf_raw_stall),
    .perf_long_cnt  (perf_long_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic set_op(input logic lng, input logic [2:0] fse, input logic [4:0] f1,
                        input logic [4:0] f2, input logic [4:0] f3, input logic fde,
                        input logic [4:0] fd);
    dec_long     = lng;
    dec_fs_en    = fse;
    dec_fs1_addr = f1;
    dec_fs2_addr = f2;
    dec_fs3_addr = f3;
    dec_fd_en    = fde;
    dec_fd_addr  = fd;
    dec_valid    = 1'b1;
  endtask

  // Present an op until it starts; returns the start cycle. Called just after
  // a rising edge, returns just after the edge following the start.
  task automatic issue(input logic lng, input logic [2:0] fse, input logic [4:0] f1,
                       input logic [4:0] f2, input logic [4:0] f3, input logic fde,
                       input logic [4:0] fd, output int at);
    at = -1;
    set_op(lng, fse, f1, f2, f3, fde, fd);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ex_start) begin
        at = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got no ex_start for fd=%0d expected start within 40 cycles", fd);
    end else begin
      step();
    end
    dec_valid = 1'b0;
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (!rst && wb_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: got sel=%0d addr=%0d expected no write (cycle %0d)",
                   wb_sel, wb_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          check("wb_order", {26'd0, wb_sel, wb_addr}, {26'd0, e});
        end
      end
    end
  endtask

  initial begin
    int s1, s2, a, a2, b, t, k;
    logic [2:0] fse;
    logic [4:0] fd2;
    int gap;

    rst = 1'b1;
    dec_valid = 1'b0;
    dec_fs_en = 3'b000;
    dec_fs1_addr = '0;
    dec_fs2_addr = '0;
    dec_fs3_addr = '0;
    dec_fd_en = 1'b0;
    dec_fd_addr = '0;
    dec_long = 1'b0;
    long_done = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {25'd0, dec_ready, ex_start, ex_long, wb_valid, wb_sel, wb_addr, halt_req}, 0);
    step();

    // RAW on fs1: second op starts LAT+1 cycles after the first
    exp_q.push_back({1'b0, 5'd5});
    issue(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, s1);
    exp_q.push_back({1'b0, 5'd6});
    issue(1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 1'b1, 5'd6, s2);
    check("raw_fs1_gap", s2 - s1, LAT + 1);
    repeat (LAT + 2) step();

    // fs2 RAW, fs3 RAW, disabled sources, WAW
    for (int i = 0; i < 4; i++) begin
      fse = (i == 0) ? 3'b010 : (i == 1) ? 3'b100 : 3'b000;
      fd2 = (i == 3) ? 5'(20 + i) : 5'(24 + i);
      gap = (i == 2) ? 1 : LAT + 1;
      exp_q.push_back({1'b0, 5'(20 + i)});
      issue(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'(20 + i), s1);
      exp_q.push_back({1'b0, fd2});
      issue(1'b0, fse, 5'(20 + i), 5'(20 + i), 5'(20 + i), 1'b1, fd2, s2);
      check($sformatf("hazard_gap_%0d", i), s2 - s1, gap);
      repeat (LAT + 2) step();
    end

    // long f2, short f4 issues under it, collision with long_done -> HOLD
    exp_q.push_back({1'b0, 5'd4});
    exp_q.push_back({1'b1, 5'd2});
    issue(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd2, a);
    issue(1'b0, 3'b001, 5'd3, 5'd0, 5'd0, 1'b1, 5'd4, a2);
    check("short_under_long", a2 - a, 1);
    @(negedge clk);
    check("halt_busy", halt_req, 1);
    step();
    step();
    long_done = 1'b1;
    @(negedge clk);
    check("collide_short_wb", {wb_valid, wb_sel, wb_addr}, {1'b1, 1'b0, 5'd4});
    step();
    long_done = 1'b0;
    exp_q.push_back({1'b0, 5'd7});
    set_op(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7);
    @(negedge clk);
    check("hold_blocks_short", dec_ready, 0);
    check("hold_halt", halt_req, 1);
    check("hold_long_wb", {wb_valid, wb_sel, wb_addr}, {1'b1, 1'b1, 5'd2});
    step();
    @(negedge clk);
    check("issue_after_hold", ex_start, 1);
    check("halt_cleared", halt_req, 0);
    step();
    dec_valid = 1'b0;
    repeat (LAT + 2) step();

    // second long op waits until the cycle after the first one writes back
    exp_q.push_back({1'b1, 5'd8});
    exp_q.push_back({1'b1, 5'd9});
    issue(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd8, b);
    set_op(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9);
    @(negedge clk);
    check("long2_blocked_1", dec_ready, 0);
    step();
    @(negedge clk);
    check("long2_blocked_2", dec_ready, 0);
    step();
    long_done = 1'b1;
    @(negedge clk);
    check("long2_blocked_done", dec_ready, 0);
    step();
    long_done = 1'b0;
    @(negedge clk);
    check("long2_accept", {ex_start, ex_long}, 2'b11);
    step();
    dec_valid = 1'b0;
    step();
    long_done = 1'b1;
    step();
    long_done = 1'b0;
    @(negedge clk);
    check("long2_done_idle", halt_req, 0);
    step();

    // long op without destination: no write on completion
    issue(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd14, t);
    step();
    long_done = 1'b1;
    @(negedge clk);
    check("long_nofd_nowb", wb_valid, 0);
    step();
    long_done = 1'b0;
    @(negedge clk);
    check("long_nofd_idle", halt_req, 0);
    step();

    // reset with a long op busy and two short ops in flight
    issue(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd10, t);
    issue(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd11, t);
    issue(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd12, t);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {25'd0, dec_ready, ex_start, ex_long, wb_valid, wb_sel, wb_addr, halt_req}, 0);
    step();
    long_done = 1'b1;
    @(negedge clk);
    check("long_done_ignored", wb_valid, 0);
    step();
    long_done = 1'b0;
    k = cyc;
    exp_q.push_back({1'b0, 5'd13});
    issue(1'b0, 3'b111, 5'd10, 5'd11, 5'd12, 1'b1, 5'd13, t);
    check("sb_clear_after_rst", t - k, 0);
    repeat (LAT + 3) step();

`ifdef FPU_SCHED_PERF_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.push_back({1'b1, 5'd15});
    issue(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd15, t);
    set_op(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd16);
    repeat (10) step();
    dec_valid = 1'b0;
    long_done = 1'b1;
    step();
    long_done = 1'b0;
    exp_q.push_back({1'b1, 5'd16});
    issue(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd16, t);
    long_done = 1'b1;
    step();
    long_done = 1'b0;
    exp_q.push_back({1'b1, 5'd17});
    issue(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd17, t);
    long_done = 1'b1;
    step();
    long_done = 1'b0;
    @(negedge clk);
    check("perf_raw_stall", perf_raw_stall, 10);
    check("perf_long_cnt", perf_long_cnt, 3);
    step();
`endif

    repeat (LAT + 3) step();
    check("exp_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
